// File: rtl/instr_fetch_queue.sv
// Show-ahead instruction/PC+2 queue between fetch and decode.
// Head outputs and fetch_stall come straight from registered state.
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] NOP_WORD = 16'h0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [15:0]                instr_in,
    input  logic [15:0]                pc_plus2_in,
    input  logic                       hit_in,
    input  logic                       flush,
    input  logic                       dec_ready,
    output logic [15:0]                instr_out,
    output logic [15:0]                pc_plus2_out,
    output logic                       valid_out,
    output logic                       fetch_stall,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   mem_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic full;
    logic not_empty;
    logic push;
    logic pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    assign full      = (count_q == FULL_CNT);
    assign not_empty = (count_q != '0);

    // A full queue refuses the hit even when the head leaves this cycle.
    assign push = hit_in && !full && !flush;
    assign pop  = not_empty && dec_ready && !flush;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (push) begin
            mem_d[wr_ptr_q] = {instr_in, pc_plus2_in};
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; only the pointers decide what is visible.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign valid_out    = not_empty;
    assign instr_out    = not_empty ? mem_q[rd_ptr_q][31:16] : NOP_WORD;
    assign pc_plus2_out = not_empty ? mem_q[rd_ptr_q][15:0]  : 16'h0000;
    assign fetch_stall  = full;
    assign count        = count_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue (DEPTH=4): fill/drain, full refusal,
// flush, wrap-around, mid-stream reset and empty pops.
module tb_instr_fetch_queue;

    logic        clk;
    logic        rst;
    logic [15:0] instr_in;
    logic [15:0] pc_plus2_in;
    logic        hit_in;
    logic        flush;
    logic        dec_ready;
    logic [15:0] instr_out;
    logic [15:0] pc_plus2_out;
    logic        valid_out;
    logic        fetch_stall;
    logic [2:0]  count;

    int n_tests;
    int n_fail;

    instr_fetch_queue #(.DEPTH(4), .NOP_WORD(16'h0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_in     (instr_in),
        .pc_plus2_in  (pc_plus2_in),
        .hit_in       (hit_in),
        .flush        (flush),
        .dec_ready    (dec_ready),
        .instr_out    (instr_out),
        .pc_plus2_out (pc_plus2_out),
        .valid_out    (valid_out),
        .fetch_stall  (fetch_stall),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [15:0] ins, input logic [15:0] pc);
        hit_in      = 1'b1;
        instr_in    = ins;
        pc_plus2_in = pc;
        step();
        hit_in      = 1'b0;
    endtask

    logic [15:0] fill_ins [4];
    logic [15:0] fill_pc  [4];

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst         = 1'b1;
        hit_in      = 1'b0;
        flush       = 1'b0;
        dec_ready   = 1'b0;
        instr_in    = 16'h0;
        pc_plus2_in = 16'h0;
        fill_ins[0] = 16'h1111; fill_pc[0] = 16'h0002;
        fill_ins[1] = 16'h2222; fill_pc[1] = 16'h0004;
        fill_ins[2] = 16'h3333; fill_pc[2] = 16'h0006;
        fill_ins[3] = 16'h4444; fill_pc[3] = 16'h0008;

        // Reset state
        step();
        step();
        rst = 1'b0;
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_stall", 32'(fetch_stall), 32'd0);
        chk("rst_instr", 32'(instr_out), 32'h0000);
        chk("rst_pc", 32'(pc_plus2_out), 32'h0000);

        // Fill with decode stalled; data must not bypass into the head
        hit_in      = 1'b1;
        instr_in    = fill_ins[0];
        pc_plus2_in = fill_pc[0];
        #1;
        chk("no_bypass_valid", 32'(valid_out), 32'd0);
        chk("no_bypass_instr", 32'(instr_out), 32'h0000);
        push_one(fill_ins[0], fill_pc[0]);
        chk("first_push_valid", 32'(valid_out), 32'd1);
        chk("first_push_instr", 32'(instr_out), 32'h1111);
        for (int i = 1; i < 4; i++) push_one(fill_ins[i], fill_pc[i]);
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_stall", 32'(fetch_stall), 32'd1);

        // Push into full queue with no pop is refused
        push_one(16'h9999, 16'h9998);
        chk("full_nopop_count", 32'(count), 32'd4);

        // Drain in order
        dec_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_instr", 32'(instr_out), 32'(fill_ins[i]));
            chk("drain_pc", 32'(pc_plus2_out), 32'(fill_pc[i]));
            step();
        end
        chk("drain_valid", 32'(valid_out), 32'd0);
        chk("drain_instr_nop", 32'(instr_out), 32'h0000);
        chk("drain_count", 32'(count), 32'd0);

        // Full queue with simultaneous pop: hit is dropped
        dec_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_one(fill_ins[i], fill_pc[i]);
        dec_ready = 1'b1;
        push_one(16'h5555, 16'h000A);
        chk("fullpop_count", 32'(count), 32'd3);
        chk("fullpop_stall", 32'(fetch_stall), 32'd0);
        for (int i = 1; i < 4; i++) begin
            chk("fullpop_drain", 32'(instr_out), 32'(fill_ins[i]));
            step();
        end
        chk("fullpop_no5555", 32'(valid_out), 32'd0);

        // Flush with a concurrent hit
        dec_ready = 1'b0;
        push_one(16'h0101, 16'h0010);
        push_one(16'h0202, 16'h0012);
        push_one(16'h0303, 16'h0014);
        chk("preflush_count", 32'(count), 32'd3);
        flush = 1'b1;
        push_one(16'hAAAA, 16'h0100);
        flush = 1'b0;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid", 32'(valid_out), 32'd0);
        push_one(16'hBBBB, 16'h0200);
        chk("postflush_head", 32'(instr_out), 32'hBBBB);
        chk("postflush_pc", 32'(pc_plus2_out), 32'h0200);
        chk("postflush_count", 32'(count), 32'd1);
        dec_ready = 1'b1;
        step();
        chk("postflush_drained", 32'(valid_out), 32'd0);

        // Wrap-around: steady push/pop pairs
        dec_ready = 1'b0;
        push_one(16'hC000, 16'h3000);
        dec_ready = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            hit_in      = 1'b1;
            instr_in    = 16'hC000 + 16'(k);
            pc_plus2_in = 16'h3000 + 16'(k);
            chk("wrap_head", 32'(instr_out), 32'(16'hC000 + 16'(k - 1)));
            step();
            chk("wrap_count", 32'(count), 32'd1);
        end
        hit_in = 1'b0;
        chk("wrap_last", 32'(instr_out), 32'hC00A);
        chk("wrap_last_pc", 32'(pc_plus2_out), 32'h300A);
        step();
        chk("wrap_empty", 32'(valid_out), 32'd0);

        // Reset mid-stream with a concurrent hit
        dec_ready = 1'b0;
        push_one(16'hD001, 16'h4002);
        push_one(16'hD002, 16'h4004);
        chk("prerst_count", 32'(count), 32'd2);
        rst = 1'b1;
        push_one(16'hDDDD, 16'h4444);
        rst = 1'b0;
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_valid", 32'(valid_out), 32'd0);
        chk("midrst_instr", 32'(instr_out), 32'h0000);
        push_one(16'hE001, 16'h5002);
        chk("postrst_head", 32'(instr_out), 32'hE001);
        chk("postrst_count", 32'(count), 32'd1);
        dec_ready = 1'b1;
        step();
        chk("postrst_drained", 32'(count), 32'd0);

        // Pops on an empty queue do nothing
        for (int i = 0; i < 5; i++) begin
            step();
            chk("emptypop_count", 32'(count), 32'd0);
        end
        dec_ready = 1'b0;
        push_one(16'hF00F, 16'h6006);
        chk("emptypop_head", 32'(instr_out), 32'hF00F);
        chk("emptypop_pc", 32'(pc_plus2_out), 32'h6006);
        chk("emptypop_cnt1", 32'(count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
